// File: rtl/led_pattern_sequencer_if.sv
// led_pattern_sequencer_if: command handshake bundle for the LED sequencer.
// cmd_duty exists only when LED_DIM_EN is defined.
interface led_pattern_sequencer_if #(
    parameter int PER_W = 16,
    parameter int CNT_W = 8,
    parameter int PWM_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [PER_W-1:0] cmd_half_period;
    logic [CNT_W-1:0] cmd_burst_cnt;
    logic [PER_W-1:0] cmd_gap;
`ifdef LED_DIM_EN
    logic [PWM_W-1:0] cmd_duty;
    modport master (output cmd_valid, cmd_mode, cmd_half_period, cmd_burst_cnt, cmd_gap, cmd_duty, input cmd_ready);
    modport slave  (input cmd_valid, cmd_mode, cmd_half_period, cmd_burst_cnt, cmd_gap, cmd_duty, output cmd_ready);
`else
    modport master (output cmd_valid, cmd_mode, cmd_half_period, cmd_burst_cnt, cmd_gap, input cmd_ready);
    modport slave  (input cmd_valid, cmd_mode, cmd_half_period, cmd_burst_cnt, cmd_gap, output cmd_ready);
`endif
    if (PER_W < 1 || CNT_W < 1 || PWM_W < 1) begin : g_bad_w
        $error("led_pattern_sequencer_if: field widths must be >= 1");
    end
endinterface

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: command-driven LED sequencer (off/on/blink/burst) timed by a prescaled tick.
// Optional LED_DIM_EN adds PWM dimming of on-phases through cmd_duty.
module led_pattern_sequencer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000,
    parameter int PER_W   = 16,
    parameter int CNT_W   = 8,
    parameter int PWM_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    led_pattern_sequencer_if.slave cmd,
    output logic                   led,
    output logic                   busy,
    output logic                   tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    if (DIV < 2 || PWM_W < 1) begin : g_bad_cfg
        $error("led_pattern_sequencer: need CLK_HZ/TICK_HZ >= 2 and PWM_W >= 1");
    end
    typedef enum logic [2:0] {S_OFF, S_ON, S_BLINK, S_BON, S_BOFF, S_GAP} state_t;
    state_t state, state_n;
    logic [PRE_W-1:0] pre;
    logic [PER_W-1:0] phase, phase_n, hp_r, gap_r, hpm1;
    logic [CNT_W-1:0] cnt_r, rem, rem_n;
    logic lit, lit_n, acc, adv, on_lvl;
    assign acc = cmd.cmd_valid && cmd.cmd_ready;
    assign tick = pre == PRE_W'(DIV - 1);
    assign adv = tick && !acc;
    assign busy = state == S_BON || state == S_BOFF;
    assign cmd.cmd_ready = !busy;
    assign hpm1 = hp_r == '0 ? '0 : hp_r - 1'b1;
    always_comb begin
        state_n = state;
        lit_n = lit;
        phase_n = phase;
        rem_n = rem;
        if (acc) begin
            phase_n = '0;
            rem_n = cmd.cmd_burst_cnt;
            case (cmd.cmd_mode)
                2'b00: begin state_n = S_OFF; lit_n = 1'b0; end
                2'b01: begin state_n = S_ON; lit_n = 1'b1; end
                2'b10: begin state_n = S_BLINK; lit_n = 1'b1; end
                default: begin
                    state_n = cmd.cmd_burst_cnt == '0 ? S_OFF : S_BON;
                    lit_n = cmd.cmd_burst_cnt != '0;
                end
            endcase
        end else if (adv) begin
            phase_n = phase + 1'b1;
            case (state)
                S_BLINK: if (phase == hpm1) begin
                    lit_n = !lit;
                    phase_n = '0;
                end
                S_BON: if (phase == hpm1) begin
                    state_n = S_BOFF;
                    lit_n = 1'b0;
                    phase_n = '0;
                end
                S_BOFF: if (phase == hpm1) begin
                    phase_n = '0;
                    rem_n = rem - 1'b1;
                    // last blink of the burst: idle through the gap, or restart at once when there is none
                    if (rem != CNT_W'(1) || gap_r == '0) begin
                        state_n = S_BON;
                        lit_n = 1'b1;
                        rem_n = rem != CNT_W'(1) ? rem - 1'b1 : cnt_r;
                    end else begin
                        state_n = S_GAP;
                    end
                end
                S_GAP: if (phase == gap_r - 1'b1) begin
                    state_n = S_BON;
                    lit_n = 1'b1;
                    phase_n = '0;
                    rem_n = cnt_r;
                end
                default: phase_n = phase;
            endcase
        end
    end
`ifdef LED_DIM_EN
    logic [PWM_W-1:0] pwm, pwm_n, duty;
    assign pwm_n = pwm + 1'b1;
    assign on_lvl = pwm_n <= (acc ? cmd.cmd_duty : duty);
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= '0;
            duty <= '0;
        end else begin
            pwm <= pwm_n;
            if (acc) duty <= cmd.cmd_duty;
        end
    end
`else
    assign on_lvl = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_OFF;
            pre <= '0;
            phase <= '0;
            rem <= '0;
            lit <= 1'b0;
            led <= 1'b0;
            hp_r <= '0;
            gap_r <= '0;
            cnt_r <= '0;
        end else begin
            state <= state_n;
            pre <= acc || tick ? '0 : pre + 1'b1;
            phase <= phase_n;
            rem <= rem_n;
            lit <= lit_n;
            led <= lit_n && on_lvl;
            if (acc) begin
                hp_r <= cmd.cmd_half_period;
                gap_r <= cmd.cmd_gap;
                cnt_r <= cmd.cmd_burst_cnt;
            end
        end
    end
endmodule
